sobel_window_ctrl: RTL

Sequencer that walks a frame stored in byte-wide pixel memory, fetches 3-row x 4-column pixel patches into the 12-byte `data_buffer` shared by the gx/gy window-pair blocks, and pulses `enable_calc` so both 3x3 windows are computed. It sits between the frame memory read port and the gradient datapath. It flags when registered gradient outputs are valid and reports the window position for the downstream magnitude/writeback stage.

---
 rtl/sobel_window_ctrl.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/sobel_window_ctrl.sv
// rtl/sobel_window_ctrl.sv - walks a frame, fetches 3x4 patches and strobes the gx/gy window pair
// Optional SOBEL_WIN_REUSE_EN: on column steps, keep columns 2,3 of the last patch and read only 6 bytes.
module sobel_window_ctrl #(
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int ADDR_W = 16
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     mem_rd_req,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic                     mem_rd_ack,
  input  logic [7:0]               mem_rd_data,
  output logic [11:0][7:0]         data_buffer,
  output logic                     enable_calc,
  output logic                     result_valid,
  output logic [$clog2(IMG_H)-1:0] win_row,
  output logic [$clog2(IMG_W)-1:0] win_col
);
  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);
  localparam logic [RW-1:0] LAST_ROW = RW'(IMG_H - 3);
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 4);
`ifdef SOBEL_WIN_REUSE_EN
  localparam bit REUSE = 1'b1;
`else
  localparam bit REUSE = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, FETCH, CALC, RESULT} state_t;

  state_t            state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [11:0][7:0]  buf_q, buf_d;
  logic              en_q, en_d;
  logic              rv_q, rv_d;
  logic [RW-1:0]     row_q, row_d;
  logic [CW-1:0]     col_q, col_d;
  logic [3:0]        idx_q, idx_d;
  logic              part_q, part_d;
  logic              shift_q, shift_d;

  logic [3:0]        idx_nx;
  logic [RW-1:0]     nrow;
  logic [CW-1:0]     ncol;
  logic              last_pair;
  logic              part_nx;

  // idx encodes the patch element as r*4 + c, so row/col offsets are its bit fields
  function automatic logic [ADDR_W-1:0] addr_of(input logic [RW-1:0] row,
                                                 input logic [CW-1:0] col,
                                                 input logic [3:0]    idx);
    logic [ADDR_W-1:0] r;
    logic [ADDR_W-1:0] c;
    r = ADDR_W'(row) + ADDR_W'(idx[3:2]);
    c = ADDR_W'(col) + ADDR_W'(idx[1:0]);
    return r * ADDR_W'(IMG_W) + c;
  endfunction

  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    req_d     = req_q;
    addr_d    = addr_q;
    buf_d     = buf_q;
    en_d      = 1'b0;
    rv_d      = 1'b0;
    row_d     = row_q;
    col_d     = col_q;
    idx_d     = idx_q;
    part_d    = part_q;
    shift_d   = 1'b0;
    idx_nx    = idx_q;
    nrow      = row_q;
    ncol      = col_q;
    last_pair = 1'b0;
    part_nx   = 1'b0;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start && !busy_q) begin
          state_d = FETCH;
          busy_d  = 1'b1;
          req_d   = 1'b1;
          addr_d  = '0;
          row_d   = '0;
          col_d   = '0;
          idx_d   = '0;
          part_d  = 1'b0;
        end
      end

      FETCH: begin
        if (shift_q) begin
          for (int r = 0; r < 3; r++) begin
            buf_d[r*4]   = buf_q[r*4+2];
            buf_d[r*4+1] = buf_q[r*4+3];
          end
        end
        if (mem_rd_ack) begin
          buf_d[idx_q] = mem_rd_data;
          if (idx_q == 4'd11) begin
            state_d = CALC;
            req_d   = 1'b0;
            en_d    = 1'b1;
          end else begin
            // partial fetches skip columns 0,1 of the next row
            idx_nx = (part_q && idx_q[1:0] == 2'd3) ? idx_q + 4'd3 : idx_q + 4'd1;
            idx_d  = idx_nx;
            addr_d = addr_of(row_q, col_q, idx_nx);
          end
        end
      end

      CALC: begin
        state_d = RESULT;
        rv_d    = 1'b1;
      end

      RESULT: begin
        last_pair = (row_q == LAST_ROW) && (col_q == LAST_COL);
        if (col_q == LAST_COL) begin
          ncol = '0;
          nrow = row_q + RW'(1);
        end else begin
          ncol = col_q + CW'(2);
          nrow = row_q;
        end
        if (last_pair) begin
          state_d = IDLE;
          done_d  = 1'b1;
          row_d   = '0;
          col_d   = '0;
        end else begin
          part_nx = REUSE && (ncol != '0);
          state_d = FETCH;
          req_d   = 1'b1;
          row_d   = nrow;
          col_d   = ncol;
          part_d  = part_nx;
          shift_d = part_nx;
          idx_d   = part_nx ? 4'd2 : 4'd0;
          addr_d  = addr_of(nrow, ncol, part_nx ? 4'd2 : 4'd0);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      buf_q   <= '0;
      en_q    <= 1'b0;
      rv_q    <= 1'b0;
      row_q   <= '0;
      col_q   <= '0;
      idx_q   <= '0;
      part_q  <= 1'b0;
      shift_q <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      buf_q   <= buf_d;
      en_q    <= en_d;
      rv_q    <= rv_d;
      row_q   <= row_d;
      col_q   <= col_d;
      idx_q   <= idx_d;
      part_q  <= part_d;
      shift_q <= shift_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign mem_rd_req   = req_q;
  assign mem_addr     = addr_q;
  assign data_buffer  = buf_q;
  assign enable_calc  = en_q;
  assign result_valid = rv_q;
  assign win_row      = row_q;
  assign win_col      = col_q;

endmodule
